mmio_bridge: RTL and testbench
==============================

Name: mmio_bridge

Overview:
Parametrised, multi-cycle successor to the single-cycle memory/IO steering path between the CPU core and the data memory.
- Takes one load/store request at a time from the core.
- Decodes it to synchronous data memory or to one of NUM_CH peripheral channels.
- Runs a per-channel ack handshake with a timeout.
- Stalls the core through cpu_ready until the access completes.
- Sits between Executs32/Decode32 and Dmemory32 plus the IO devices.

Parameters:
DATA_W, 32, data width of the CPU, memory and each IO channel.
ADDR_W, 32, CPU byte-address width.
MEM_AW, 14, data-memory word-address width; mem_addr = cpu_addr[MEM_AW+1:2].
IO_LSB, 10, cpu_addr[ADDR_W-1:IO_LSB] all ones selects IO space.
NUM_CH, 4, number of IO channels, 1..16.
CH_SPAN_LOG2, 4, log2 of the bytes per channel window.
TIMEOUT, 15, IO wait cycles before an error response, >=1.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; all state cleared immediately
cpu_req  in  1  access request, held by the core until cpu_ready
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  byte address (ALU result)
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  load data, valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
cpu_err  out  1  high with cpu_ready when the access failed
mem_we  out  1  data-memory write enable
mem_addr  out  MEM_AW  data-memory word address
mem_wdata  out  DATA_W  data-memory write data
mem_rdata  in  DATA_W  data-memory read data, valid 1 cycle after address
io_sel  out  NUM_CH  one-hot channel select
io_re  out  1  IO read strobe
io_we  out  1  IO write strobe
io_off  out  CH_SPAN_LOG2  byte offset inside the channel window
io_wdata  out  DATA_W  IO write data
io_rdata  in  NUM_CH*DATA_W  channel k read data in slice [k*DATA_W +: DATA_W]
io_ack  in  NUM_CH  per-channel completion

Behaviour:
- All outputs are registered.
- Reset values: cpu_rdata=0, cpu_ready=0, cpu_err=0, mem_we=0, mem_addr=0, mem_wdata=0, io_sel=0, io_re=0, io_we=0, io_off=0, io_wdata=0. State = IDLE, timeout counter = 0.
- FSM states: IDLE, MEM, MEM_RD, IO_WAIT, RESP.
- IDLE: at an edge with cpu_req=1 the request is accepted (edge E0) and address, data and we are latched.
  - Non-IO address -> MEM. mem_addr and mem_wdata are driven; mem_we = cpu_we.
  - IO address with channel index cpu_addr[CH_SPAN_LOG2 +: 4] < NUM_CH -> IO_WAIT. io_sel = onehot(idx), io_re = !cpu_we, io_we = cpu_we, io_off/io_wdata driven, counter = 0.
  - IO address with index >= NUM_CH -> RESP with cpu_err=1 and cpu_rdata=0.
- MEM: at E1, mem_we -> 0.
  - Store -> RESP.
  - Load -> MEM_RD.
- MEM_RD: at E2, cpu_rdata <= mem_rdata -> RESP.
- IO_WAIT: strobes, sel, off and wdata are held constant. At each edge:
  - io_ack[idx]=1 -> capture the io_rdata slice (stores capture 0), clear strobes/sel -> RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT with no ack: clear strobes, cpu_rdata=0, cpu_err=1 -> RESP.
  - Ack and expiry on the same edge: ack wins, no error.
  - io_ack bits of unselected channels are ignored.
- RESP: cpu_ready=1 (and cpu_err as set) for exactly one cycle; cpu_req is ignored. Next edge -> IDLE; cpu_ready and cpu_err clear, cpu_rdata holds its value.
- Latency, counted from the accepting edge to cpu_ready high:
  - Store to memory: ready after E1.
  - Load from memory: ready after E2.
  - IO: ready after the edge that samples the ack.
  - Unmapped IO: ready after E0.
- No pipelining: the earliest next accept is the edge ending RESP+1 (IDLE).
- Reset mid-transaction: strobes drop asynchronously, the access is abandoned, and no cpu_ready is issued.

Decomposition:
- Package mmio_pkg:
  - State enum (IDLE, MEM, MEM_RD, IO_WAIT, RESP).
  - Channel-index width constant (4).
  - Error read value (0).
- Sub-module mmio_timeout_ctr: parametrised TIMEOUT counter with clear, enable and expire. Clocked by clock, async-reset by reset.

Test Plan:
1. Store 0x12345678 to 0x00000040, then load it -> mem_we pulses one cycle with mem_addr=0x010. The load returns 0x12345678, ready 2 edges after accept, cpu_err=0.
2. Load from 0xFFFFFC10 (ch1) with io_ack[1] asserted 3 cycles later and slice 0xA5A5 -> io_sel=4'b0010, io_re held 3 cycles, cpu_rdata=0x0000A5A5, cpu_ready one pulse.
3. Store to ch2 with no ack, TIMEOUT=15 -> strobes held 15 edges then cleared, cpu_ready=1, cpu_err=1, cpu_rdata=0.
4. Ack arriving on exactly the TIMEOUT edge -> data captured, cpu_err=0.
5. NUM_CH=4, access 0xFFFFFC50 (idx 5) -> no strobe, ready after E0 with cpu_err=1.
6. Assert reset during IO_WAIT -> io_re/io_sel drop immediately with no cpu_ready. After release, a memory load completes normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared types and constants for the CPU memory/IO bridge.
package mmio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEM,
    MEM_RD,
    IO_WAIT,
    RESP
  } state_t;

  localparam int CH_IDX_W  = 4;
  localparam int ERR_RDATA = 0;

endpackage

// File: rtl/mmio_timeout_ctr.sv
// Wait-cycle counter for IO accesses; expire fires on the last allowed edge.
module mmio_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Combinational so the edge that would be TIMEOUT can still lose to an ack
  assign expire = enable && (count == LAST);

endmodule

// File: rtl/mmio_bridge.sv
// Multi-cycle load/store bridge: data memory or NUM_CH acked IO channels.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int MEM_AW       = 14,
  parameter int IO_LSB       = 10,
  parameter int NUM_CH       = 4,
  parameter int CH_SPAN_LOG2 = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_ready,
  output logic                     cpu_err,
  output logic                     mem_we,
  output logic [MEM_AW-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [NUM_CH-1:0]        io_sel,
  output logic                     io_re,
  output logic                     io_we,
  output logic [CH_SPAN_LOG2-1:0]  io_off,
  output logic [DATA_W-1:0]        io_wdata,
  input  logic [NUM_CH*DATA_W-1:0] io_rdata,
  input  logic [NUM_CH-1:0]        io_ack
);

  state_t state, state_n;

  logic [DATA_W-1:0]       rdata_n, wdata_n, io_wdata_n, ack_data;
  logic                    ready_n, err_n, mem_we_n, re_n, we_n;
  logic [MEM_AW-1:0]       maddr_n;
  logic [NUM_CH-1:0]       sel_n, onehot;
  logic [CH_SPAN_LOG2-1:0] off_n;
  logic [CH_IDX_W-1:0]     idx;
  logic                    is_io, idx_ok, acked, expire;

  assign is_io  = &cpu_addr[ADDR_W-1:IO_LSB];
  assign idx    = cpu_addr[CH_SPAN_LOG2 +: CH_IDX_W];
  assign idx_ok = {1'b0, idx} < (CH_IDX_W + 1)'(NUM_CH);
  // io_sel is one-hot while waiting, so masking ignores other channels
  assign acked  = |(io_ack & io_sel);

  always_comb begin
    onehot   = '0;
    ack_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      onehot[k] = (idx == CH_IDX_W'(k));
      if (io_sel[k]) begin
        ack_data = ack_data | io_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  mmio_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clock (clock),
    .reset (reset),
    .clear (state == IDLE),
    .enable(state == IO_WAIT),
    .expire(expire)
  );

  always_comb begin
    state_n    = state;
    rdata_n    = cpu_rdata;
    ready_n    = 1'b0;
    err_n      = 1'b0;
    mem_we_n   = mem_we;
    maddr_n    = mem_addr;
    wdata_n    = mem_wdata;
    sel_n      = io_sel;
    re_n       = io_re;
    we_n       = io_we;
    off_n      = io_off;
    io_wdata_n = io_wdata;
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          unique case (1'b1)
            !is_io: begin
              state_n  = MEM;
              maddr_n  = cpu_addr[MEM_AW+1:2];
              wdata_n  = cpu_wdata;
              mem_we_n = cpu_we;
            end
            is_io && idx_ok: begin
              state_n    = IO_WAIT;
              sel_n      = onehot;
              re_n       = !cpu_we;
              we_n       = cpu_we;
              off_n      = cpu_addr[CH_SPAN_LOG2-1:0];
              io_wdata_n = cpu_wdata;
            end
            is_io && !idx_ok: begin
              state_n = RESP;
              ready_n = 1'b1;
              err_n   = 1'b1;
              rdata_n = DATA_W'(ERR_RDATA);
            end
          endcase
        end
      end
      MEM: begin
        mem_we_n = 1'b0;
        if (mem_we) begin
          state_n = RESP;
          ready_n = 1'b1;
        end else begin
          state_n = MEM_RD;
        end
      end
      MEM_RD: begin
        rdata_n = mem_rdata;
        state_n = RESP;
        ready_n = 1'b1;
      end
      IO_WAIT: begin
        if (acked || expire) begin
          sel_n   = '0;
          re_n    = 1'b0;
          we_n    = 1'b0;
          state_n = RESP;
          ready_n = 1'b1;
          err_n   = !acked;
          rdata_n = (acked && !io_we) ? ack_data : DATA_W'(ERR_RDATA);
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      io_sel    <= '0;
      io_re     <= 1'b0;
      io_we     <= 1'b0;
      io_off    <= '0;
      io_wdata  <= '0;
    end else begin
      state     <= state_n;
      cpu_rdata <= rdata_n;
      cpu_ready <= ready_n;
      cpu_err   <= err_n;
      mem_we    <= mem_we_n;
      mem_addr  <= maddr_n;
      mem_wdata <= wdata_n;
      io_sel    <= sel_n;
      io_re     <= re_n;
      io_we     <= we_n;
      io_off    <= off_n;
      io_wdata  <= io_wdata_n;
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: random memory/IO traffic vs a reference model.
module tb_mmio_bridge;

  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int TO  = 15;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cpu_req = 1'b0;
  logic             cpu_we = 1'b0;
  logic [31:0]      cpu_addr = '0;
  logic [31:0]      cpu_wdata = '0;
  logic [31:0]      cpu_rdata;
  logic             cpu_ready, cpu_err;
  logic             mem_we;
  logic [13:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic [NCH-1:0]   io_sel;
  logic             io_re, io_we;
  logic [3:0]       io_off;
  logic [31:0]      io_wdata;
  logic [NCH*DW-1:0] io_rdata = '0;
  logic [NCH-1:0]   io_ack = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          chk_rd;
    int          lat;
    int          stb;
    logic [3:0]  sel;
    logic [3:0]  off;
    int          mwe;
    logic [13:0] maddr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem[int];
  logic [31:0] chdata[NCH];
  logic [31:0] dmem[0:16383];
  int          checks = 0;
  int          errors = 0;

  mmio_bridge #(
    .DATA_W(32), .ADDR_W(32), .MEM_AW(14), .IO_LSB(10),
    .NUM_CH(NCH), .CH_SPAN_LOG2(4), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_sel(io_sel), .io_re(io_re), .io_we(io_we),
    .io_off(io_off), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack)
  );

  initial forever #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 16384; i++) dmem[i] = '0;
  end

  always @(posedge clock) begin
    if (mem_we) dmem[mem_addr] <= mem_wdata;
    mem_rdata <= dmem[mem_addr];
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: accumulate per-transaction observations, compare on cpu_ready
  int         busy = 0, stb = 0, mwe = 0;
  logic [3:0] sel_seen = '0, off_seen = '0;
  logic [13:0] maddr_seen = '0;

  always @(negedge clock) begin
    if (reset) begin
      busy = 0; stb = 0; mwe = 0; sel_seen = '0;
    end else begin
      if (io_re || io_we) begin
        stb++;
        sel_seen = sel_seen | io_sel;
        off_seen = io_off;
      end
      if (mem_we) begin
        mwe++;
        maddr_seen = mem_addr;
      end
      if (cpu_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 32'(cpu_ready), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.chk_rd) chk("rdata", cpu_rdata, e.rdata);
          chk("err", 32'(cpu_err), 32'(e.err));
          chk("latency", 32'(busy - 1), 32'(e.lat));
          chk("strobe_cycles", 32'(stb), 32'(e.stb));
          chk("mem_we_cycles", 32'(mwe), 32'(e.mwe));
          if (e.stb > 0) begin
            chk("io_sel", 32'(sel_seen), 32'(e.sel));
            chk("io_off", 32'(off_seen), 32'(e.off));
          end
          if (e.mwe > 0) chk("mem_addr", 32'(maddr_seen), 32'(e.maddr));
        end
        busy = 0; stb = 0; mwe = 0; sel_seen = '0;
      end else if (cpu_req) begin
        busy++;
      end
    end
  end

  // ack_d: edge (counted after accept) that samples the ack; 0 = never
  task automatic run_txn(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_d,
                         input bit noise);
    exp_t       e;
    int         word, idx, c;
    bit         io, done;
    logic [3:0] mask;
    io   = addr >= 32'hFFFF_FC00;
    idx  = int'((addr >> 4) & 32'hF);
    word = int'((addr >> 2) & 32'h3FFF);
    mask = '0;
    e = '{rdata: 32'd0, err: 1'b0, chk_rd: 1'b1, lat: 0, stb: 0,
          sel: 4'd0, off: 4'(addr & 32'hF), mwe: 0, maddr: 14'(word)};
    if (!io) begin
      if (we) begin
        ref_mem[word] = wdata;
        e.lat = 1; e.mwe = 1; e.chk_rd = 1'b0;
      end else begin
        e.rdata = ref_mem.exists(word) ? ref_mem[word] : 32'd0;
        e.lat = 2;
      end
    end else if (idx >= NCH) begin
      e.err = 1'b1;
    end else begin
      mask  = 4'(1 << idx);
      e.sel = mask;
      if (ack_d >= 1 && ack_d <= TO) begin
        e.lat = ack_d; e.stb = ack_d;
        e.rdata = we ? 32'd0 : chdata[idx];
      end else begin
        e.err = 1'b1; e.lat = TO; e.stb = TO;
      end
    end
    sb.push_back(e);
    for (int k = 0; k < NCH; k++) io_rdata[k*DW +: DW] = chdata[k];
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    c = 0; done = 1'b0;
    while (!done && c < 100) begin
      @(posedge clock); #1;
      io_ack = noise ? (4'($urandom) & ~mask) : 4'd0;
      if (ack_d >= 1 && c == ack_d - 1) io_ack = io_ack | mask;
      done = cpu_ready;
      c++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_timeout: got no cpu_ready in %0d cycles, expected one", c);
    end
    @(posedge clock); #1;
    io_ack = '0;
    if ($urandom_range(0, 3) == 0) begin
      cpu_req = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NCH; k++) chdata[k] = $urandom;
    #2;
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_cpu_err", 32'(cpu_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_io_sel", 32'(io_sel), 32'd0);
    chk("rst_io_strobes", {30'd0, io_re, io_we}, 32'd0);
    chk("rst_io_off", 32'(io_off), 32'd0);
    chk("rst_io_wdata", io_wdata, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    run_txn(1'b1, 32'h0000_0040, 32'h1234_5678, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0040, 32'd0, 0, 1'b0);
    chdata[1] = 32'h0000_A5A5;
    run_txn(1'b0, 32'hFFFF_FC10, 32'd0, 3, 1'b0);
    run_txn(1'b1, 32'hFFFF_FC20, 32'hCAFE_F00D, 0, 1'b0);
    run_txn(1'b0, 32'hFFFF_FC30, 32'd0, TO, 1'b0);
    run_txn(1'b0, 32'hFFFF_FC50, 32'd0, 0, 1'b0);

    // Abort an IO wait with reset; no response may follow
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFF_FC00;
    repeat (3) @(posedge clock);
    #1;
    chk("pre_reset_io_re", 32'(io_re), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_io_re", 32'(io_re), 32'd0);
    chk("reset_io_sel", 32'(io_sel), 32'd0);
    chk("reset_cpu_ready", 32'(cpu_ready), 32'd0);
    cpu_req = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    run_txn(1'b0, 32'h0000_0040, 32'd0, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      int          kind, d;
      logic [31:0] a;
      for (int k = 0; k < NCH; k++) chdata[k] = $urandom;
      kind = $urandom_range(0, 9);
      d = ($urandom_range(0, 3) == 0) ? TO : $urandom_range(1, TO);
      if (kind < 4) begin
        a = ($urandom & 32'h7FFF_0000) | (32'($urandom_range(0, 31)) << 2)
            | ($urandom & 32'h3);
      end else begin
        a = 32'hFFFF_FC00 | (($urandom & 32'h3) << 8) | ($urandom & 32'hF)
            | (32'((kind == 8) ? $urandom_range(NCH, 15)
                               : $urandom_range(0, NCH - 1)) << 4);
      end
      run_txn(1'($urandom), a, $urandom, (kind == 9) ? 0 : d, 1'b1);
    end

    repeat (3) @(posedge clock);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
